// File: rtl/end_display_pkg.sv
// Shared constants for the end-of-game screen: RGB565 colours, pattern
// mode encodings, the default palette and a small index helper.
package end_display_pkg;

   localparam logic [15:0] RED     = 16'hF800;
   localparam logic [15:0] YELLOW  = 16'hFFE0;
   localparam logic [15:0] GREEN   = 16'h07E0;
   localparam logic [15:0] BLUE    = 16'h001F;
   localparam logic [15:0] CYAN    = 16'h07FF;
   localparam logic [15:0] MAGENTA = 16'hF81F;
   localparam logic [15:0] WHITE   = 16'hFFFF;
   localparam logic [15:0] BLACK   = 16'h0000;

   typedef enum logic [1:0] {
      MODE_SOLID   = 2'b00,
      MODE_BARS    = 2'b01,
      MODE_CHECKER = 2'b10,
      MODE_FREEZE  = 2'b11
   } mode_e;

   // Entry 0 sits in the least significant 16 bits.
   localparam logic [127:0] DEFAULT_PALETTE =
      {BLACK, WHITE, MAGENTA, CYAN, BLUE, GREEN, YELLOW, RED};

   // Step a palette index forward, wrapping to 0 after the last active entry.
   function automatic logic [2:0] wrap_inc(input logic [2:0] idx,
                                           input logic [2:0] last);
      return (idx == last) ? 3'd0 : idx + 3'd1;
   endfunction

endpackage

// File: rtl/flash_sequencer.sv
// Colour sequencer: dwells SEG_CYCLES run-cycles on each palette index,
// walks 0..NUM_COLORS-1 and pulses seq_wrap as the index returns to 0.
module flash_sequencer
   import end_display_pkg::*;
#(
   parameter int NUM_COLORS = 3,
   parameter int SEG_CYCLES = 416667
) (
   input  logic       vga_clk,
   input  logic       sys_rst,
   input  logic       run,
   output logic [2:0] color_idx,
   output logic       seq_wrap
);

   localparam int               CNT_W    = $clog2(SEG_CYCLES) + 1;
   localparam logic [CNT_W-1:0] SEG_LAST = CNT_W'(SEG_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [2:0]       IDX_LAST = 3'(NUM_COLORS - 1);

   logic [CNT_W-1:0] seg_cnt_r;
   logic [2:0]       color_idx_r;
   logic             seq_wrap_r;
   logic             seg_done_s;

   // Last cycle of the current colour segment.
   always_comb begin
      seg_done_s = (seg_cnt_r == SEG_LAST);
   end

   // Segment counter, index advance and wrap pulse; everything holds while run is low.
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         seg_cnt_r   <= '0;
         color_idx_r <= 3'd0;
         seq_wrap_r  <= 1'b0;
      end else if (run) begin
         if (seg_done_s) begin
            seg_cnt_r   <= '0;
            color_idx_r <= wrap_inc(color_idx_r, IDX_LAST);
            seq_wrap_r  <= (color_idx_r == IDX_LAST);
         end else begin
            seg_cnt_r   <= seg_cnt_r + CNT_ONE;
            seq_wrap_r  <= 1'b0;
         end
      end else begin
         seq_wrap_r <= 1'b0;
      end
   end

   assign color_idx = color_idx_r;
   assign seq_wrap  = seq_wrap_r;

endmodule

// File: rtl/end_display_gen.sv
// End-of-game screen generator: frame-aligned mode latch, palette pattern
// select (solid / bars / checker / freeze) and the registered RGB565 output.
module end_display_gen
   import end_display_pkg::*;
#(
   parameter int                     NUM_COLORS = 3,
   parameter int                     SEG_CYCLES = 416667,
   parameter int                     COLOR_W    = 16,
   parameter logic [8*COLOR_W-1:0]   PALETTE    = DEFAULT_PALETTE,
   parameter int                     H_DISPLAY  = 640,
   parameter int                     V_DISPLAY  = 480,
   parameter int                     BAR_LOG2   = 5,
   parameter int                     TILE_LOG2  = 5
) (
   input  logic               vga_clk,
   input  logic               sys_rst,
   input  logic               enable,
   input  logic [1:0]         mode,
   input  logic [9:0]         pix_x,
   input  logic [9:0]         pix_y,
   output logic [COLOR_W-1:0] pix_data,
   output logic [2:0]         color_idx,
   output logic               seq_wrap
);

   localparam logic [2:0]  IDX_LAST = 3'(NUM_COLORS - 1);
   localparam logic [10:0] NC_W     = 11'(NUM_COLORS);

   mode_e              mode_q_r;
   logic [COLOR_W-1:0] pix_data_r;
   logic               run_s;
   logic               frame_start_s;
   logic               blank_s;
   logic [2:0]         seq_idx_s;
   logic [2:0]         next_idx_s;
   logic [9:0]         bar_s;
   logic [10:0]        bar_sum_s;
   logic [2:0]         bar_idx_s;
   logic               parity_s;
   logic [COLOR_W-1:0] color_s;

   function automatic logic [COLOR_W-1:0] pal_at(input logic [2:0] idx);
      return PALETTE[idx*COLOR_W +: COLOR_W];
   endfunction

   flash_sequencer #(
      .NUM_COLORS (NUM_COLORS),
      .SEG_CYCLES (SEG_CYCLES)
   ) u_seq (
      .vga_clk   (vga_clk),
      .sys_rst   (sys_rst),
      .run       (run_s),
      .color_idx (seq_idx_s),
      .seq_wrap  (seq_wrap)
   );

   // Sequencer gating, frame-start detect and the pattern index arithmetic.
   always_comb begin
      run_s         = enable && (mode_q_r != MODE_FREEZE);
      frame_start_s = (pix_x == 10'd0) && (pix_y == 10'd0);
      blank_s       = (pix_x >= 10'(H_DISPLAY)) || (pix_y >= 10'(V_DISPLAY));
      next_idx_s    = wrap_inc(seq_idx_s, IDX_LAST);
      bar_s         = pix_x >> BAR_LOG2;
      bar_sum_s     = {8'd0, seq_idx_s} + {1'b0, bar_s};
      bar_idx_s     = 3'(bar_sum_s % NC_W);
      parity_s      = pix_x[TILE_LOG2] ^ pix_y[TILE_LOG2];
   end

   // Pixel colour for the current position under the latched mode.
   always_comb begin
      color_s = '0;
      if (blank_s) begin
         color_s = '0;
      end else begin
         case (mode_q_r)
            MODE_BARS:    color_s = pal_at(bar_idx_s);
            MODE_CHECKER: color_s = pal_at(parity_s ? next_idx_s : seq_idx_s);
            MODE_SOLID:   color_s = pal_at(seq_idx_s);
            MODE_FREEZE:  color_s = pal_at(seq_idx_s);
            default:      color_s = pal_at(seq_idx_s);
         endcase
      end
   end

   // Mode only changes at the top-left pixel so a frame never tears.
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         mode_q_r <= MODE_SOLID;
      end else if (frame_start_s) begin
         mode_q_r <= mode_e'(mode);
      end
   end

   // Output pixel register.
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         pix_data_r <= '0;
      end else begin
         pix_data_r <= color_s;
      end
   end

   assign pix_data  = pix_data_r;
   assign color_idx = seq_idx_s;

endmodule

// File: tb/tb_end_display_gen.sv
// Self-checking bench for end_display_gen: directed scenarios plus random
// stimulus against an arithmetic reference model. A second instance with
// SEG_CYCLES=1 / NUM_COLORS=2 shares the stimulus.
module tb_end_display_gen;

   localparam int NC  = 3;
   localparam int SEG = 4;
   localparam int NC2  = 2;
   localparam int SEG2 = 1;

   logic        vga_clk = 1'b0;
   logic        sys_rst;
   logic        enable;
   logic [1:0]  mode;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic [15:0] pix_data;
   logic [2:0]  color_idx;
   logic        seq_wrap;
   logic [15:0] pix_data2;
   logic [2:0]  color_idx2;
   logic        seq_wrap2;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] pal [8] = '{16'hF800, 16'hFFE0, 16'h07E0, 16'h001F,
                            16'h07FF, 16'hF81F, 16'hFFFF, 16'h0000};

   // Model state: number of run cycles since reset and the latched mode.
   int          m_runs = 0;
   int          m_mq   = 0;
   logic [15:0] m_pix, m_pix2;
   logic        m_wrap, m_wrap2;

   always #5 vga_clk = ~vga_clk;

   end_display_gen #(.NUM_COLORS(NC), .SEG_CYCLES(SEG)) dut (
      .vga_clk   (vga_clk),
      .sys_rst   (sys_rst),
      .enable    (enable),
      .mode      (mode),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_data  (pix_data),
      .color_idx (color_idx),
      .seq_wrap  (seq_wrap)
   );

   end_display_gen #(.NUM_COLORS(NC2), .SEG_CYCLES(SEG2)) dut_fast (
      .vga_clk   (vga_clk),
      .sys_rst   (sys_rst),
      .enable    (enable),
      .mode      (mode),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_data  (pix_data2),
      .color_idx (color_idx2),
      .seq_wrap  (seq_wrap2)
   );

   function automatic int ref_idx(input int runs, input int seg, input int nc);
      return (runs / seg) % nc;
   endfunction

   function automatic logic [15:0] ref_color(input int mq, input int idx, input int nc,
                                             input int px, input int py);
      int tx, ty;
      if (px >= 640 || py >= 480) return 16'h0000;
      if (mq == 1) return pal[(idx + px / 32) % nc];
      if (mq == 2) begin
         tx = (px / 32) % 2;
         ty = (py / 32) % 2;
         return (tx != ty) ? pal[(idx + 1) % nc] : pal[idx];
      end
      return pal[idx];
   endfunction

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model across the edge, check both DUTs.
   task automatic step(input logic r, input logic en, input logic [1:0] md,
                       input int px, input int py);
      bit run;
      sys_rst = r;
      enable  = en;
      mode    = md;
      pix_x   = 10'(px);
      pix_y   = 10'(py);
      @(posedge vga_clk);
      if (r) begin
         m_runs = 0; m_mq = 0;
         m_pix = 16'h0000; m_pix2 = 16'h0000;
         m_wrap = 1'b0; m_wrap2 = 1'b0;
      end else begin
         m_pix  = ref_color(m_mq, ref_idx(m_runs, SEG, NC), NC, px, py);
         m_pix2 = ref_color(m_mq, ref_idx(m_runs, SEG2, NC2), NC2, px, py);
         run = en && (m_mq != 3);
         if (run) m_runs++;
         m_wrap  = run && ((m_runs % (SEG * NC)) == 0);
         m_wrap2 = run && ((m_runs % (SEG2 * NC2)) == 0);
         if (px == 0 && py == 0) m_mq = int'(md);
      end
      #1;
      chk_eq("pix_data",   pix_data,   m_pix);
      chk_eq("color_idx",  color_idx,  ref_idx(m_runs, SEG, NC));
      chk_eq("seq_wrap",   seq_wrap,   m_wrap);
      chk_eq("pix_data2",  pix_data2,  m_pix2);
      chk_eq("color_idx2", color_idx2, ref_idx(m_runs, SEG2, NC2));
      chk_eq("seq_wrap2",  seq_wrap2,  m_wrap2);
   endtask

   // Run enabled at a non-frame-start pixel until the model index hits target (bounded).
   task automatic run_to_idx(input int target, input logic [1:0] md);
      for (int i = 0; i < 64; i++) begin
         if (ref_idx(m_runs, SEG, NC) == target) break;
         step(1'b0, 1'b1, md, 100, 50);
      end
      chk_eq("reach_idx", color_idx, target);
   endtask

   initial begin
      int wraps;
      int hold;
      sys_rst = 1'b1; enable = 1'b0; mode = 2'b00; pix_x = 10'd10; pix_y = 10'd10;

      // Reset, then solid flashing through the palette.
      step(1'b1, 1'b0, 2'b00, 10, 10);
      step(1'b1, 1'b0, 2'b00, 10, 10);
      chk_eq("rst_pix", pix_data, 16'h0000);
      wraps = 0;
      for (int i = 0; i < 13; i++) begin
         step(1'b0, 1'b1, 2'b00, 10, 10);
         if (i == 0) chk_eq("solid_first", pix_data, 16'hF800);
         if (i == 4) chk_eq("solid_second", pix_data, 16'hFFE0);
         if (i == 8) chk_eq("solid_third", pix_data, 16'h07E0);
         if (seq_wrap) wraps++;
      end
      chk_eq("solid_back", pix_data, 16'hF800);
      chk_eq("wrap_count", wraps, 1);

      // Pause at seg_cnt=2, resume, step exactly two cycles later.
      for (int i = 0; i < 8; i++) begin
         if (m_runs % SEG == 2) break;
         step(1'b0, 1'b1, 2'b00, 10, 10);
      end
      hold = ref_idx(m_runs, SEG, NC);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 2'b00, 10, 10);
      chk_eq("pause_hold", color_idx, hold);
      step(1'b0, 1'b1, 2'b00, 10, 10);
      chk_eq("resume_1", color_idx, hold);
      step(1'b0, 1'b1, 2'b00, 10, 10);
      chk_eq("resume_2", color_idx, (hold + 1) % NC);

      // Mode request mid-frame waits for the frame start.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b01, 100, 50);
      run_to_idx(0, 2'b01);
      step(1'b0, 1'b0, 2'b01, 0, 0);
      step(1'b0, 1'b0, 2'b01, 64, 0);
      chk_eq("bars_64_0", pix_data, 16'h07E0);

      // Checkerboard at color_idx=1.
      run_to_idx(1, 2'b10);
      step(1'b0, 1'b0, 2'b10, 0, 0);
      step(1'b0, 1'b0, 2'b10, 0, 0);
      chk_eq("chk_0_0", pix_data, 16'hFFE0);
      step(1'b0, 1'b0, 2'b10, 32, 0);
      chk_eq("chk_32_0", pix_data, 16'h07E0);
      step(1'b0, 1'b0, 2'b10, 32, 32);
      chk_eq("chk_32_32", pix_data, 16'hFFE0);

      // Blanking in every mode.
      for (int m = 0; m < 4; m++) begin
         step(1'b0, 1'b0, 2'(m), 0, 0);
         step(1'b0, 1'b0, 2'(m), 640, 10);
         chk_eq("blank_x", pix_data, 16'h0000);
         step(1'b0, 1'b0, 2'(m), 10, 480);
         chk_eq("blank_y", pix_data, 16'h0000);
      end

      // Freeze (latched above) holds the index even with enable high.
      hold = ref_idx(m_runs, SEG, NC);
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 2'b11, 10, 10);
      chk_eq("freeze_hold", color_idx, hold);

      // Reset in the middle of checker mode with color_idx=2.
      step(1'b0, 1'b0, 2'b10, 0, 0);
      run_to_idx(2, 2'b10);
      step(1'b1, 1'b1, 2'b10, 100, 50);
      chk_eq("midrst_idx", color_idx, 0);
      chk_eq("midrst_pix", pix_data, 16'h0000);
      step(1'b0, 1'b0, 2'b10, 40, 10);
      chk_eq("midrst_solid", pix_data, 16'hF800);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         int px, py;
         if ($urandom_range(0, 7) == 0) begin
            px = 0; py = 0;
         end else begin
            px = $urandom_range(0, 700);
            py = $urandom_range(0, 520);
         end
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)), px, py);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
